// File: rtl/ucsbece154a_mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// wait-counter width and the address error check.
package ucsbece154a_mem_responder_pkg;

   // Wide enough for WAIT_CYCLES up to 15
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      state_mem_Idle = 2'd0,
      state_mem_Wait = 2'd1,
      state_mem_Resp = 2'd2
   } mem_state_t;

   // A request is in error when it is not word aligned or when its word
   // index (relative to base, wrapping 32-bit arithmetic) is past the RAM.
   function automatic logic addr_err(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth);
      logic [31:0] off;
      off = addr - base;
      return (addr[1:0] != 2'b00) || ((off >> 2) >= 32'(depth));
   endfunction

endpackage

// File: rtl/ucsbece154a_mem_responder_ram_1rw.sv
// Single-port DEPTH x 32 word RAM with registered read. Reads and writes
// never coincide in this system, so no read-during-write behaviour is needed.
module ucsbece154a_mem_responder_ram_1rw #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Write port and registered read port; contents survive reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ucsbece154a_mem_responder.sv
// Memory-side responder for the multicycle core: accepts one word request,
// waits WAIT_CYCLES, then returns a one-cycle ready pulse with read data
// or an error flag.
module ucsbece154a_mem_responder
   import ucsbece154a_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
   localparam logic NO_WAIT = (WAIT_CYCLES == 0);

   mem_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             we_q;
   logic             err_q;
   logic [AW-1:0]    idx_q;
   logic [31:0]      wdata_q;
   logic             ready_q;
   logic             err_o_q;
   logic             zero_q;   // force rdata_o to zero (after reset / error)

   logic [31:0]      req_off;
   logic [AW-1:0]    req_idx;
   logic             req_err;
   logic             unused_off_bits;

   logic             resp_from_idle;
   logic             resp_from_wait;
   logic             enter_resp;
   logic             cur_we;
   logic             cur_err;
   logic [AW-1:0]    cur_idx;
   logic [31:0]      cur_wdata;
   logic             ram_we;
   logic             ram_re;
   logic [31:0]      ram_rdata;

   assign req_off         = addr_i - BASE_ADDR;
   assign req_idx         = req_off[AW+1:2];
   assign req_err         = addr_err(addr_i, BASE_ADDR, DEPTH);
   assign unused_off_bits = ^{req_off[31:AW+2], req_off[1:0]};

   // The RAM access happens on the edge that enters RESP. With no wait
   // states that edge is the acceptance edge, so use the live request
   // fields; otherwise use the fields latched at acceptance.
   assign resp_from_idle = (state_q == state_mem_Idle) && req_i && NO_WAIT;
   assign resp_from_wait = (state_q == state_mem_Wait) && (cnt_q == CNT_W'(1));
   assign enter_resp     = resp_from_idle || resp_from_wait;

   assign cur_we    = resp_from_idle ? we_i    : we_q;
   assign cur_err   = resp_from_idle ? req_err : err_q;
   assign cur_idx   = resp_from_idle ? req_idx : idx_q;
   assign cur_wdata = resp_from_idle ? wdata_i : wdata_q;

   // Reset during the final wait cycle drops the access
   assign ram_we = enter_resp && cur_we  && !cur_err && !reset;
   assign ram_re = enter_resp && !cur_we && !cur_err && !reset;

   ucsbece154a_mem_responder_ram_1rw #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (cur_idx),
      .wdata_i (cur_wdata),
      .rdata_o (ram_rdata)
   );

   // Request FSM: latch on acceptance, count wait states, pulse ready
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= state_mem_Idle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         err_o_q <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         case (state_q)
            state_mem_Idle: begin
               if (req_i) begin
                  we_q    <= we_i;
                  err_q   <= req_err;
                  idx_q   <= req_idx;
                  wdata_q <= wdata_i;
                  cnt_q   <= WAIT_INIT;
                  if (NO_WAIT) begin
                     state_q <= state_mem_Resp;
                     ready_q <= 1'b1;
                     err_o_q <= req_err;
                     if (req_err) begin
                        zero_q <= 1'b1;
                     end else if (!we_i) begin
                        zero_q <= 1'b0;
                     end
                  end else begin
                     state_q <= state_mem_Wait;
                  end
               end
            end
            state_mem_Wait: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= state_mem_Resp;
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
                  err_o_q <= err_q;
                  if (err_q) begin
                     zero_q <= 1'b1;
                  end else if (!we_q) begin
                     zero_q <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            state_mem_Resp: begin
               state_q <= state_mem_Idle;
               ready_q <= 1'b0;
               err_o_q <= 1'b0;
            end
            default: begin
               state_q <= state_mem_Idle;
               ready_q <= 1'b0;
               err_o_q <= 1'b0;
            end
         endcase
      end
   end

   // RAM read register holds between reads; zero_q masks it after errors
   assign rdata_o = zero_q ? 32'h0 : ram_rdata;
   assign ready_o = ready_q;
   assign err_o   = err_o_q;

endmodule

// File: tb/tb_ucsbece154a_mem_responder.sv
// Bench for the memory responder: two instances (2 wait states at base 0,
// zero wait states at base 0x1000), a driver issuing requests and pushing
// expected responses, and a monitor popping and comparing them.
module tb_ucsbece154a_mem_responder;

   localparam int unsigned W0 = 2;
   localparam int unsigned W1 = 0;
   localparam logic [31:0] B0 = 32'h0000_0000;
   localparam logic [31:0] B1 = 32'h0000_1000;
   localparam int unsigned D  = 64;

   logic        clk = 1'b0;
   logic        rst   [2];
   logic        req   [2];
   logic        we    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic        ready [2];
   logic [31:0] rdata [2];
   logic        err   [2];

   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   typedef struct {
      int unsigned cyc;
      logic        we;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   logic [31:0] mdl [2][D];
   int unsigned last_resp [2];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ucsbece154a_mem_responder #(.DEPTH(D), .WAIT_CYCLES(W0), .BASE_ADDR(B0)) dut0 (
      .clk(clk), .reset(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
      .wdata_i(wdata[0]), .ready_o(ready[0]), .rdata_o(rdata[0]), .err_o(err[0])
   );

   ucsbece154a_mem_responder #(.DEPTH(D), .WAIT_CYCLES(W1), .BASE_ADDR(B1)) dut1 (
      .clk(clk), .reset(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
      .wdata_i(wdata[1]), .ready_o(ready[1]), .rdata_o(rdata[1]), .err_o(err[1])
   );

   function automatic logic [31:0] base_of(input int d);
      return (d == 0) ? B0 : B1;
   endfunction

   function automatic int unsigned wait_of(input int d);
      return (d == 0) ? W0 : W1;
   endfunction

   // Reference rules: misaligned, or word offset from base (mod 2^32) >= D
   function automatic bit m_err(input int d, input logic [31:0] a);
      logic [31:0] off;
      off = a - base_of(d);
      return (a % 4 != 0) || (off / 4 >= D);
   endfunction

   function automatic int m_idx(input int d, input logic [31:0] a);
      logic [31:0] off;
      off = (a - base_of(d)) / 4;
      return int'(off[5:0]);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst[d] && ready[d] === 1'b1) begin
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  n_chk++;
                  $display("FAIL unexpected_ready dut%0d: got ready at cycle %0d want none", d, cyc);
               end else begin
                  if (d == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  $display("resp dut%0d cyc=%0d we=%0b err=%0b rdata=%h", d, cyc, e.we, err[d], rdata[d]);
                  check($sformatf("latency_dut%0d", d), cyc, e.cyc);
                  check($sformatf("err_dut%0d", d), {31'b0, err[d]}, {31'b0, e.err});
                  if (!e.we || e.err)
                     check($sformatf("rdata_dut%0d", d), rdata[d], e.rdata);
               end
            end
         end
      end
   endtask

   // Present a request at a negedge and wait for its response. With chaos,
   // the inputs are scrambled every cycle after acceptance.
   task automatic do_req(input int d, input bit w, input logic [31:0] a,
                         input logic [31:0] dv, input bit chaos);
      exp_t        e;
      int unsigned acc;
      bit          got;
      req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = dv;
      acc = (cyc == last_resp[d]) ? cyc + 1 : cyc;
      e.cyc = acc + 1 + wait_of(d);
      e.we  = w;
      e.err = m_err(d, a);
      if (e.err) e.rdata = 32'h0;
      else if (w) begin
         mdl[d][m_idx(d, a)] = dv;
         e.rdata = 32'h0;
      end else e.rdata = mdl[d][m_idx(d, a)];
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (ready[d] === 1'b1) begin
            got = 1'b1;
            last_resp[d] = cyc;
         end else if (chaos && cyc > acc) begin
            req[d]   = 1'($urandom_range(0, 1));
            we[d]    = 1'($urandom_range(0, 1));
            addr[d]  = $urandom;
            wdata[d] = $urandom;
         end
      end
      if (!got) begin
         n_chk++;
         $display("FAIL timeout dut%0d: got no ready want ready by cycle %0d", d, e.cyc);
      end
   endtask

   task automatic idle(input int d, input int n);
      req[d] = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Start a write and reset the responder during its wait period
   task automatic reset_mid_write(input int d, input logic [31:0] a, input logic [31:0] dv);
      int unsigned acc;
      req[d] = 1'b1; we[d] = 1'b1; addr[d] = a; wdata[d] = dv;
      acc = (cyc == last_resp[d]) ? cyc + 1 : cyc;
      while (cyc < acc + 1) @(negedge clk);
      rst[d] = 1'b1; req[d] = 1'b0;
      @(negedge clk);
      rst[d] = 1'b0;
      last_resp[d] = 0;
      check($sformatf("rst_ready_dut%0d", d), {31'b0, ready[d]}, 32'h0);
      check($sformatf("rst_rdata_dut%0d", d), rdata[d], 32'h0);
      repeat (wait_of(d) + 3) @(negedge clk);
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      int          ix;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
         addr[d] = '0; wdata[d] = '0; last_resp[d] = 0;
      end
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_ready_dut%0d", d), {31'b0, ready[d]}, 32'h0);
         check($sformatf("reset_err_dut%0d", d), {31'b0, err[d]}, 32'h0);
         check($sformatf("reset_rdata_dut%0d", d), rdata[d], 32'h0);
      end

      // Two wait states: write, read back, hold, misaligned write
      do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      idle(0, 1);
      do_req(0, 1'b0, 32'h10, 32'h0, 1'b0);
      idle(0, 4);
      check("rdata_hold_dut0", rdata[0], 32'hDEAD_BEEF);
      do_req(0, 1'b1, 32'h12, 32'h5555_5555, 1'b0);
      idle(0, 1);
      do_req(0, 1'b0, 32'h10, 32'h0, 1'b0);
      idle(0, 1);

      // Reset in the middle of a write must drop it
      do_req(0, 1'b1, 32'h20, 32'h1111_1111, 1'b0);
      idle(0, 1);
      reset_mid_write(0, 32'h20, 32'h2222_2222);
      do_req(0, 1'b0, 32'h20, 32'h0, 1'b0);
      idle(0, 1);

      // Inputs scrambled during WAIT/RESP must not disturb the response
      do_req(0, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b1);
      do_req(0, 1'b0, 32'h30, 32'h0, 1'b1);
      do_req(0, 1'b0, 32'h10, 32'h0, 1'b1);
      idle(0, 2);

      // Zero wait states, base 0x1000: range edges and back-to-back
      do_req(1, 1'b1, 32'h10FC, 32'h0BAD_CAFE, 1'b0);
      do_req(1, 1'b0, 32'h1100, 32'h0, 1'b0);
      do_req(1, 1'b0, 32'h0FFC, 32'h0, 1'b0);
      do_req(1, 1'b0, 32'h10FC, 32'h0, 1'b0);
      do_req(1, 1'b1, 32'h1000, 32'h1234_5678, 1'b0);
      do_req(1, 1'b0, 32'h1000, 32'h0, 1'b0);
      idle(1, 2);
      do_req(1, 1'b0, 32'h1002, 32'h0, 1'b0);
      idle(1, 2);

      // Prefill 16 words per instance so random reads hit written data
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++)
            do_req(d, 1'b1, base_of(d) + 32'(i * 4), $urandom, 1'b0);
         idle(d, 1);
      end

      // Randomized mix of reads, writes, error addresses and gaps
      for (int d = 0; d < 2; d++) begin
         for (int t = 0; t < 30; t++) begin
            r  = int'($urandom_range(0, 9));
            ix = int'($urandom_range(0, 15));
            if (r == 0)
               a = base_of(d) + 32'(ix * 4) + $urandom_range(1, 3);
            else if (r == 1)
               a = base_of(d) + 32'(D * 4) + 32'($urandom_range(0, 63) * 4);
            else if (r == 2)
               a = base_of(d) - 32'($urandom_range(1, 8) * 4);
            else
               a = base_of(d) + 32'(ix * 4);
            do_req(d, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle(d, int'($urandom_range(1, 3)));
         end
         idle(d, 3);
      end

      repeat (5) @(negedge clk);
      check("pending_dut0", q0.size(), 32'h0);
      check("pending_dut1", q1.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
